xmit_a_arb: RTL and testbench
=============================

Name: xmit_a_arb

Overview:
Round-robin arbiter/sequencer that shares one xmit_a transmitter between NUM_REQ byte-stream requesters. Grants the transmitter for a whole packet, which ends on req_last or at the length limit. Drives the transmitter's byte/strobe inputs (xmit_a_in1/xmit_a_in2) and takes back-pressure from its xmit_a_out2 (busy). Sits between the packet sources and the xmit_a instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MAX_PKT_LEN, 64, maximum bytes per grant; reaching it without last forces an abort
IDLE_GAP, 1, idle cycles between packets (0 = none)
STALL_CYCLES, 16, stall limit used only by the optional feature

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  per-requester last byte of packet
req_ready  out  NUM_REQ  per-requester accept
xmit_data  out  8  byte to transmitter (xmit_a_in1)
xmit_strobe  out  1  byte strobe to transmitter (xmit_a_in2)
xmit_busy  in  1  transmitter busy (xmit_a_out2)
grant_id  out  clog2(NUM_REQ)  current or last granted requester
grant_active  out  1  packet in progress
pkt_abort  out  1  one-cycle pulse on forced packet end

Behaviour:
- Reset (asynchronous, immediate): state IDLE, rr_ptr=0, byte count=0, gap count=0; all outputs 0.
- FSM states IDLE, XFER, GAP; state and all outputs except req_ready are registered.
- IDLE: if any req_valid is high, pick the first valid index searching from rr_ptr upward with wrap. Load grant_id, set grant_active=1, go to XFER next cycle. If no request, stay in IDLE.
- XFER: req_ready[grant_id] = (state==XFER) & !xmit_busy, combinational. All other req_ready bits are 0.
- A handshake is req_valid[g] & req_ready[g]. The cycle after a handshake: xmit_strobe=1 and xmit_data=byte. Otherwise xmit_strobe=0 and xmit_data holds its last value.
- Latency: from req_valid rising in IDLE, the earliest handshake is 1 cycle later and the first strobe is 2 cycles later.
- Byte count increments on each handshake. Count width is clog2(MAX_PKT_LEN+1).
- Normal end: handshake with req_last=1 goes to GAP.
- Forced end: the handshake that brings the count to MAX_PKT_LEN with req_last=0 goes to GAP and pulses pkt_abort=1 for the following cycle. If last=1 on that same byte, it is a normal end with no abort.
- On leaving XFER: rr_ptr = (grant_id+1) mod NUM_REQ, count cleared, grant_active cleared the next cycle.
- Granted requester drops valid mid-packet: grant is held and the FSM waits (see Optional Feature).
- xmit_busy high: ready low in the same cycle, no handshake and no strobe; no byte is lost or duplicated.
- GAP: wait IDLE_GAP cycles, then IDLE. If IDLE_GAP=0, XFER goes directly to IDLE.
- Requests arriving during XFER or GAP are evaluated only in IDLE. A new grant never overlaps the last strobe of the previous packet.
- grant_id holds its value after the packet; qualify it with grant_active.
- Reset mid-packet: partial packet dropped silently, no pkt_abort pulse. After release, arbitration restarts from requester 0.

Optional Feature:
Macro XMIT_A_ARB_STALL_TIMEOUT_EN.
- Defined: a stall counter runs in XFER while req_valid[grant_id]=0. It clears on valid. At STALL_CYCLES consecutive cycles the packet ends as a forced end: pkt_abort pulse, GAP, rr_ptr advances. Busy cycles with valid high do not count.
- Undefined: no counter, grant is held indefinitely, STALL_CYCLES is ignored.

Decomposition:
- Package xmit_a_pkg holds: DATA_W=8, the state typedef (IDLE/XFER/GAP), and a clog2 helper function.
- One sub-module, xmit_a_rr_pick: combinational round-robin picker. Inputs req vector and rr_ptr; outputs found flag and index.

Test Plan:
- Reset, then requester 2 sends A1,A2,A3 (last on A3) → grant_id=2 one cycle after valid; strobes carry A1,A2,A3; grant_active low after the 1-cycle gap; pkt_abort never asserts.
- All four requesters send continuous 2-byte packets from reset → grant order 0,1,2,3,0,1; 1 gap cycle between packets; no strobe overlap.
- xmit_busy high for 3 cycles after the 2nd byte of a 5-byte packet → req_ready and strobe low for those 3 cycles; all 5 bytes delivered in order exactly once.
- Requester 1 sends 64 bytes without last → pkt_abort pulses once after the 64th strobe; requester 2 (pending) granted next.
- rst_n low while the 5th byte of requester 3's packet is in flight → all outputs 0 asynchronously, no abort pulse; after release, requesters 1 and 3 pending → requester 1 granted.
- Granted requester drops valid for 16 cycles → with the macro, abort pulse and rr advance; without it, grant still held after 100 cycles, and the packet completes when valid returns.

Source files
------------

// File: rtl/xmit_a_pkg.sv
// Shared types and helpers for the xmit_a round-robin arbiter.
package xmit_a_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } xmit_a_state_e;

  // Ceiling log2 with a floor of 1 so single-value ranges still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xmit_a_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, with wrap.
module xmit_a_rr_pick
  import xmit_a_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_o && req_i[(int'(rr_ptr_i) + i) % NUM_REQ]) begin
        found_o = 1'b1;
        idx_o   = ID_W'((int'(rr_ptr_i) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/xmit_a_arb.sv
// Shares one xmit_a transmitter between NUM_REQ byte streams, one whole packet per grant.
// Optional stall timeout: define XMIT_A_ARB_STALL_TIMEOUT_EN.
module xmit_a_arb
  import xmit_a_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_PKT_LEN  = 64,
  parameter int IDLE_GAP     = 1,
  parameter int STALL_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          xmit_data,
  output logic                       xmit_strobe,
  input  logic                       xmit_busy,
  output logic [clog2(NUM_REQ)-1:0]  grant_id,
  output logic                       grant_active,
  output logic                       pkt_abort,
  output xmit_a_state_e              dbg_state
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_PKT_LEN + 1);
  localparam int GAP_W = clog2(IDLE_GAP + 1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_PKT_LEN < 1 || IDLE_GAP < 0 || STALL_CYCLES < 1)
  begin : g_bad_cfg
    $error("xmit_a_arb: unsupported parameter set");
  end

  xmit_a_state_e      state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               grant_active_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [DATA_W-1:0]  xmit_data_q;
  logic               xmit_strobe_q;
  logic               pkt_abort_q;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  xmit_a_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  // Valid/ready: a byte moves on a rising edge where req_valid[g] and req_ready[g]
  // are both high; ready depends only on our state and xmit_busy, never on valid.
  always_comb begin
    req_ready = '0;
    if (state_q == XFER && !xmit_busy) req_ready[grant_id_q] = 1'b1;
  end

  logic              gnt_valid, gnt_last, hs, at_max;
  logic              len_abort, stall_abort, end_pkt;
  logic [DATA_W-1:0] gnt_byte;
  logic [ID_W-1:0]   rr_next;

  assign gnt_valid = req_valid[grant_id_q];
  assign gnt_last  = req_last[grant_id_q];
  assign gnt_byte  = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
  assign hs        = (state_q == XFER) && !xmit_busy && gnt_valid;
  assign at_max    = (cnt_q == CNT_W'(MAX_PKT_LEN - 1));
  assign len_abort = hs && !gnt_last && at_max;
  assign end_pkt   = (hs && (gnt_last || at_max)) || stall_abort;
  assign rr_next   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

`ifdef XMIT_A_ARB_STALL_TIMEOUT_EN
  localparam int STALL_W = clog2(STALL_CYCLES + 1);
  logic [STALL_W-1:0] stall_q;

  // Only cycles with the granted requester's valid low count; busy stalls do not.
  assign stall_abort = (state_q == XFER) && !gnt_valid &&
                       (stall_q == STALL_W'(STALL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q != XFER || gnt_valid || stall_abort) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end
`else
  assign stall_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      cnt_q          <= '0;
      gap_q          <= '0;
      xmit_data_q    <= '0;
      xmit_strobe_q  <= 1'b0;
      pkt_abort_q    <= 1'b0;
    end else begin
      xmit_strobe_q <= hs;
      pkt_abort_q   <= len_abort || stall_abort;
      if (hs) xmit_data_q <= gnt_byte;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q     <= pick_idx;
            grant_active_q <= 1'b1;
            state_q        <= XFER;
          end
        end
        XFER: begin
          if (hs) cnt_q <= cnt_q + CNT_W'(1);
          if (end_pkt) begin
            cnt_q          <= '0;
            gap_q          <= '0;
            rr_ptr_q       <= rr_next;
            grant_active_q <= 1'b0;
            state_q        <= (IDLE_GAP == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (int'(gap_q) >= IDLE_GAP - 1) state_q <= IDLE;
          else gap_q <= gap_q + GAP_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign xmit_data    = xmit_data_q;
  assign xmit_strobe  = xmit_strobe_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;
  assign pkt_abort    = pkt_abort_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_xmit_a_arb.sv
// Directed bench for xmit_a_arb: byte-stream sources, strobe monitor, per-scenario checks.
module tb_xmit_a_arb;
  import xmit_a_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_last, req_ready;
  logic [8*N-1:0]    req_data;
  logic [7:0]        xmit_data;
  logic              xmit_strobe, xmit_busy;
  logic [1:0]        grant_id;
  logic              grant_active, pkt_abort;
  xmit_a_state_e     dbg_state;

  int tests_run = 0, tests_failed = 0;

  always #5 clk = ~clk;

  xmit_a_arb #(.NUM_REQ(N), .MAX_PKT_LEN(64), .IDLE_GAP(1), .STALL_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .xmit_data(xmit_data),
    .xmit_strobe(xmit_strobe), .xmit_busy(xmit_busy), .grant_id(grant_id),
    .grant_active(grant_active), .pkt_abort(pkt_abort), .dbg_state(dbg_state)
  );

  // Sources: per-requester byte lists presented in order, popped on handshake.
  logic [7:0] src_data[N][128];
  logic       src_lastf[N][128];
  int         src_len[N], src_pos[N];
  logic [N-1:0] src_hold = '0, hs_mask = '0;

  logic [7:0] got_q[$];
  logic [1:0] gnt_log[$];
  int abort_cnt = 0, abort_at = -1, gap_cyc = 0, overlap_cnt = 0;
  logic prev_ga = 1'b0;

  task automatic load_src(input int r, input int len, input int pkt_len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      src_data[r][k]  = base + 8'(k);
      src_lastf[r][k] = ((k % pkt_len) == pkt_len - 1);
    end
    src_len[r] = len;
    src_pos[r] = 0;
  endtask

  function automatic bit all_consumed();
    for (int i = 0; i < N; i++) if (src_pos[i] < src_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (hs_mask[i]) src_pos[i]++;
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i] && !src_hold[i]) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = src_lastf[i][src_pos[i]];
        req_data[8*i +: 8] = src_data[i][src_pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    hs_mask = req_valid & req_ready;
    if (rst_n) begin
      if (xmit_strobe) got_q.push_back(xmit_data);
      if (pkt_abort) begin abort_cnt++; abort_at = got_q.size(); end
      if (grant_active && !prev_ga) begin
        gnt_log.push_back(grant_id);
        if (xmit_strobe) overlap_cnt++;
      end
      if (dbg_state == GAP) gap_cyc++;
      prev_ga = grant_active;
    end else begin
      prev_ga = 1'b0;
    end
  end

  task automatic clear_logs();
    got_q.delete(); gnt_log.delete();
    abort_cnt = 0; abort_at = -1; gap_cyc = 0; overlap_cnt = 0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int c = 0;
    while (c < max_cyc && !(all_consumed() && dbg_state == IDLE && !grant_active && !xmit_strobe)) begin
      @(negedge clk); c++;
    end
    tests_run++;
    if (c >= max_cyc) begin
      tests_failed++;
      $display("FAIL %s_done: timeout after %0d cycles, state=%0d", name, c, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, xmit_data, xmit_strobe, grant_id, grant_active, pkt_abort} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, need 0",
               {req_ready, xmit_data, xmit_strobe, grant_id, grant_active, pkt_abort});
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d, need IDLE", dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (grant_active !== 1'b0 || xmit_strobe !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle: ga=%b strobe=%b, need 0 0", grant_active, xmit_strobe);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_q[$];
    bit bad;
    @(negedge clk);
    clear_logs();
    load_src(2, 3, 3, 8'hA1);
    @(negedge clk);
    tests_run++;
    if (grant_active !== 1'b0) begin
      tests_failed++; $display("FAIL single_pregrant: ga=%b, need 0", grant_active);
    end
    @(negedge clk);
    tests_run++;
    if (grant_active !== 1'b1 || grant_id !== 2'd2) begin
      tests_failed++; $display("FAIL single_grant: ga=%b id=%0d, need 1 2", grant_active, grant_id);
    end
    tests_run++;
    if (req_ready !== 4'b0100 || xmit_strobe !== 1'b0) begin
      tests_failed++; $display("FAIL single_ready: ready=%b strobe=%b, need 0100 0", req_ready, xmit_strobe);
    end
    @(negedge clk);
    tests_run++;
    if (xmit_strobe !== 1'b1 || xmit_data !== 8'hA1) begin
      tests_failed++; $display("FAIL single_first: strobe=%b data=%h, need 1 a1", xmit_strobe, xmit_data);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (xmit_strobe !== 1'b1 || xmit_data !== 8'hA3 || grant_active !== 1'b0 || dbg_state !== GAP) begin
      tests_failed++;
      $display("FAIL single_last: strobe=%b data=%h ga=%b st=%0d, need 1 a3 0 GAP",
               xmit_strobe, xmit_data, grant_active, dbg_state);
    end
    @(negedge clk);
    tests_run++;
    if (dbg_state !== IDLE || xmit_strobe !== 1'b0) begin
      tests_failed++; $display("FAIL single_gap: st=%0d strobe=%b, need IDLE 0", dbg_state, xmit_strobe);
    end
    wait_done("single", 20);
    exp_q = '{8'hA1, 8'hA2, 8'hA3};
    bad = (got_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    tests_run++;
    if (bad || abort_cnt != 0) begin
      tests_failed++;
      $display("FAIL single_data: %0d bytes %0d aborts, need 3 bytes a1..a3 0 aborts", got_q.size(), abort_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q[$];
    logic [1:0] exp_g[$];
    bit bad;
    @(negedge clk);
    rst_n = 1'b0;
    clear_logs();
    for (int i = 0; i < N; i++) load_src(i, 4, 2, 8'(8'h10 * (i + 1)));
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("rr", 200);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        exp_g.push_back(2'(i));
        exp_q.push_back(8'(8'h10 * (i + 1) + 2 * k));
        exp_q.push_back(8'(8'h10 * (i + 1) + 2 * k + 1));
      end
    bad = (gnt_log.size() != exp_g.size());
    for (int i = 0; i < exp_g.size() && !bad; i++) if (gnt_log[i] !== exp_g[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL rr_order: %0d grants first=%0d, need 8 grants 0,1,2,3,0,1,2,3",
               gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : 2'd0);
    end
    bad = (got_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL rr_data: %0d bytes out of order or wrong, need 16", got_q.size());
    end
    tests_run++;
    if (gap_cyc != 8 || overlap_cnt != 0 || abort_cnt != 0) begin
      tests_failed++;
      $display("FAIL rr_gap: gap=%0d overlap=%0d abort=%0d, need 8 0 0", gap_cyc, overlap_cnt, abort_cnt);
    end
  endtask

  task automatic test_busy();
    logic [7:0] exp_q[$];
    bit bad;
    @(negedge clk);
    clear_logs();
    load_src(0, 5, 5, 8'h50);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 xmit_busy = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0000 || xmit_strobe !== 1'b1 || xmit_data !== 8'h51) begin
      tests_failed++;
      $display("FAIL busy_c1: ready=%b strobe=%b data=%h, need 0000 1 51", req_ready, xmit_strobe, xmit_data);
    end
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (req_ready !== 4'b0000 || xmit_strobe !== 1'b0) begin
        tests_failed++; $display("FAIL busy_c%0d: ready=%b strobe=%b, need 0000 0", c, req_ready, xmit_strobe);
      end
    end
    @(posedge clk);
    #2 xmit_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if (xmit_strobe !== 1'b0 || req_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL busy_release: strobe=%b ready=%b, need 0 0001", xmit_strobe, req_ready);
    end
    @(negedge clk);
    tests_run++;
    if (xmit_strobe !== 1'b1 || xmit_data !== 8'h52) begin
      tests_failed++; $display("FAIL busy_resume: strobe=%b data=%h, need 1 52", xmit_strobe, xmit_data);
    end
    wait_done("busy", 30);
    for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h50 + k));
    bad = (got_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL busy_data: %0d bytes, need 50..54 exactly once", got_q.size());
    end
  endtask

  task automatic test_max_len();
    logic [7:0] exp_q[$];
    logic [1:0] exp_g[$];
    bit bad;
    @(negedge clk);
    clear_logs();
    load_src(1, 66, 66, 8'h00);
    load_src(2, 2, 2, 8'hC0);
    wait_done("maxlen", 300);
    tests_run++;
    if (abort_cnt != 1 || abort_at != 64) begin
      tests_failed++; $display("FAIL maxlen_abort: count=%0d at_byte=%0d, need 1 64", abort_cnt, abort_at);
    end
    exp_g = '{2'd1, 2'd2, 2'd1};
    bad = (gnt_log.size() != exp_g.size());
    for (int i = 0; i < exp_g.size() && !bad; i++) if (gnt_log[i] !== exp_g[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL maxlen_order: %0d grants, need 1,2,1", gnt_log.size());
    end
    for (int k = 0; k < 64; k++) exp_q.push_back(8'(k));
    exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    exp_q.push_back(8'd64); exp_q.push_back(8'd65);
    bad = (got_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL maxlen_data: %0d bytes, need 68 in order", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_q[$];
    logic [1:0] exp_g[$];
    bit bad;
    int c = 0;
    @(negedge clk);
    clear_logs();
    load_src(3, 8, 8, 8'h30);
    while (got_q.size() < 4 && c < 30) begin @(negedge clk); c++; end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (c >= 30 || {req_ready, xmit_data, xmit_strobe, grant_id, grant_active, pkt_abort} !== 16'h0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got %h after %0d cycles, need 0",
               {req_ready, xmit_data, xmit_strobe, grant_id, grant_active, pkt_abort}, c);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin src_len[i] = 0; src_pos[i] = 0; end
    load_src(1, 2, 2, 8'h61);
    load_src(3, 2, 2, 8'h71);
    tests_run++;
    if (abort_cnt != 0 || pkt_abort !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_noabort: count=%0d pulse=%b, need 0 0", abort_cnt, pkt_abort);
    end
    clear_logs();
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("rstmid", 40);
    exp_g = '{2'd1, 2'd3};
    bad = (gnt_log.size() != exp_g.size());
    for (int i = 0; i < exp_g.size() && !bad; i++) if (gnt_log[i] !== exp_g[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL rstmid_order: %0d grants first=%0d, need 1,3",
               gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : 2'd0);
    end
    exp_q = '{8'h61, 8'h62, 8'h71, 8'h72};
    bad = (got_q.size() != exp_q.size()) || (abort_cnt != 0);
    for (int i = 0; i < exp_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL rstmid_data: %0d bytes %0d aborts, need 61 62 71 72, 0", got_q.size(), abort_cnt);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_q[$];
    logic [1:0] exp_g[$];
    bit bad;
    int c = 0;
    @(negedge clk);
    clear_logs();
    load_src(0, 4, 4, 8'h80);
    load_src(1, 2, 2, 8'h90);
    repeat (3) @(negedge clk);
    src_hold[0] = 1'b1;
`ifdef XMIT_A_ARB_STALL_TIMEOUT_EN
    while (c < 40 && pkt_abort !== 1'b1) begin @(negedge clk); c++; end
    tests_run++;
    if (c != 17) begin
      tests_failed++; $display("FAIL stall_timeout: abort after %0d cycles, need 17", c);
    end
    src_hold[0] = 1'b0;
    wait_done("stall", 40);
    exp_g = '{2'd0, 2'd1, 2'd0};
    exp_q = '{8'h80, 8'h81, 8'h90, 8'h91, 8'h82, 8'h83};
    tests_run++;
    if (abort_cnt != 1) begin
      tests_failed++; $display("FAIL stall_abort_count: got %0d, need 1", abort_cnt);
    end
`else
    repeat (100) @(negedge clk);
    c = 100;
    tests_run++;
    if (grant_active !== 1'b1 || grant_id !== 2'd0 || dbg_state !== XFER || abort_cnt != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: ga=%b id=%0d st=%0d aborts=%0d after %0d cycles, need 1 0 XFER 0",
               grant_active, grant_id, dbg_state, abort_cnt, c);
    end
    src_hold[0] = 1'b0;
    wait_done("stall", 40);
    exp_g = '{2'd0, 2'd1};
    exp_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h90, 8'h91};
    tests_run++;
    if (abort_cnt != 0) begin
      tests_failed++; $display("FAIL stall_abort_count: got %0d, need 0", abort_cnt);
    end
`endif
    bad = (gnt_log.size() != exp_g.size());
    for (int i = 0; i < exp_g.size() && !bad; i++) if (gnt_log[i] !== exp_g[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL stall_order: %0d grants, need %0d", gnt_log.size(), exp_g.size());
    end
    bad = (got_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL stall_data: %0d bytes, need 6 in order", got_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    xmit_busy = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin src_len[i] = 0; src_pos[i] = 0; end
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_max_len();
    test_reset_mid();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
